// File: rtl/int_ctrl_if.sv
// rtl/int_ctrl_if.sv - register bus bundle between the CPU bus glue and int_ctrl
interface int_ctrl_if;
    logic        cs;
    logic        mem_w;
    logic [2:0]  addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        ready;

    modport master (output cs, mem_w, addr, wdata, input rdata, ready);
    modport slave  (input cs, mem_w, addr, wdata, output rdata, ready);
endinterface

// File: rtl/int_ctrl.sv
// rtl/int_ctrl.sv - priority-vectored interrupt controller with claim/EOI handshake
module int_ctrl #(
    parameter int NSRC = 8,
    parameter int IDW  = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [NSRC-1:0]  irq_in,
    int_ctrl_if.slave        bus,
    output logic             INT,
    output logic [IDW-1:0]   int_id
);
    localparam logic [2:0] A_PEND = 3'd0;
    localparam logic [2:0] A_MASK = 3'd1;
    localparam logic [2:0] A_EDGE = 3'd2;
    localparam logic [2:0] A_VEC  = 3'd3;
    localparam logic [2:0] A_ISR  = 3'd4;
    localparam logic [2:0] A_EOI  = 3'd5;
    localparam logic [IDW:0] NONE = (IDW+1)'(NSRC);

    logic [NSRC-1:0] s1, s2, s3;
    logic [NSRC-1:0] pend, mask, edge_sel, isr;

    logic [NSRC-1:0] elig, p_oh, q_oh;
    logic [IDW:0]    p, q;
    logic            has_elig, win;

    // p/q are one bit wider than int_id so that q can hold NSRC ("nothing in service").
    always_comb begin
        elig     = pend & mask;
        p        = '0;
        p_oh     = '0;
        has_elig = 1'b0;
        q        = NONE;
        q_oh     = '0;
        for (int i = NSRC - 1; i >= 0; i--) begin
            if (elig[i]) begin
                p        = i[IDW:0];
                p_oh     = '0;
                p_oh[i]  = 1'b1;
                has_elig = 1'b1;
            end
            if (isr[i]) begin
                q       = i[IDW:0];
                q_oh    = '0;
                q_oh[i] = 1'b1;
            end
        end
        win = has_elig && (p < q);
    end

    logic            rd, wr, claim, eoi;
    logic [NSRC-1:0] clr, pend_nx, isr_nx;
    logic [31:0]     rd_val;

    always_comb begin
        rd    = bus.cs & ~bus.mem_w;
        wr    = bus.cs & bus.mem_w;
        claim = rd && (bus.addr == A_VEC) && win;
        eoi   = wr && (bus.addr == A_EOI);
        clr   = '0;
        if (wr && (bus.addr == A_PEND)) clr = bus.wdata[NSRC-1:0];
        if (claim) clr = clr | p_oh;
        // Edge bits: a new edge overrides a same-cycle clear. Level bits follow s2.
        pend_nx = (edge_sel & ((pend & ~clr) | (s2 & ~s3))) | (~edge_sel & s2);
        isr_nx  = isr | (claim ? p_oh : '0);
        if (eoi) isr_nx = isr_nx & ~q_oh;
        case (bus.addr)
            A_PEND:  rd_val = 32'(pend);
            A_MASK:  rd_val = 32'(mask);
            A_EDGE:  rd_val = 32'(edge_sel);
            A_VEC:   rd_val = win ? (32'h8000_0000 | 32'(p[IDW-1:0])) : 32'd0;
            A_ISR:   rd_val = 32'(isr);
            default: rd_val = 32'd0;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s1        <= '0;
            s2        <= '0;
            s3        <= '0;
            pend      <= '0;
            mask      <= '0;
            edge_sel  <= '0;
            isr       <= '0;
            bus.rdata <= '0;
            bus.ready <= 1'b0;
            INT       <= 1'b0;
            int_id    <= '0;
        end else begin
            s1        <= irq_in;
            s2        <= s1;
            s3        <= s2;
            pend      <= pend_nx;
            isr       <= isr_nx;
            if (wr && (bus.addr == A_MASK)) mask     <= bus.wdata[NSRC-1:0];
            if (wr && (bus.addr == A_EDGE)) edge_sel <= bus.wdata[NSRC-1:0];
            bus.ready <= bus.cs;
            if (rd) bus.rdata <= rd_val;
            INT       <= win;
            int_id    <= win ? p[IDW-1:0] : '0;
        end
    end
endmodule

// File: tb/tb_int_ctrl.sv
// tb/tb_int_ctrl.sv - randomized and directed bench for int_ctrl against a behavioural model
module tb_int_ctrl;
    localparam int N = 8;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic [N-1:0] irq = '0;
    logic         int_o;
    logic [4:0]   id_o;
    int           checks = 0;
    int           failures = 0;
    bit           cmp_on = 1'b0;

    int_ctrl_if bus ();

    int_ctrl #(.NSRC(N), .IDW(5)) dut (
        .clk    (clk),
        .reset  (reset),
        .irq_in (irq),
        .bus    (bus),
        .INT    (int_o),
        .int_id (id_o)
    );

    always #5 clk = ~clk;

    // Model state: registers plus a history of irq samples from the last three edges.
    bit [N-1:0]  m_pend, m_mask, m_edge, m_isr;
    bit [N-1:0]  h0, h1, h2;
    logic [31:0] m_rdata;
    bit          m_ready, m_int;
    int          m_id;

    bit [N-1:0]  n_pend, n_mask, n_edge, n_isr, clrv;
    logic [31:0] n_rdata;
    int          m_p, m_q;
    bit          m_win, m_rd, m_wr;

    function automatic int lowest(input bit [N-1:0] v);
        for (int i = 0; i < N; i++) if (v[i]) return i;
        return N;
    endfunction

    always_comb begin
        m_p    = lowest(m_pend & m_mask);
        m_q    = lowest(m_isr);
        m_win  = (m_p < N) && (m_p < m_q);
        m_rd   = bus.cs && !bus.mem_w;
        m_wr   = bus.cs && bus.mem_w;
        n_mask = m_mask;
        n_edge = m_edge;
        n_isr  = m_isr;
        n_rdata = m_rdata;
        clrv   = '0;
        if (m_wr && bus.addr == 3'd0) clrv = bus.wdata[N-1:0];
        if (m_wr && bus.addr == 3'd1) n_mask = bus.wdata[N-1:0];
        if (m_wr && bus.addr == 3'd2) n_edge = bus.wdata[N-1:0];
        for (int i = 0; i < N; i++) begin
            if (m_rd && bus.addr == 3'd3 && m_win && i == m_p) begin
                n_isr[i] = 1'b1;
                clrv[i]  = 1'b1;
            end
            if (m_wr && bus.addr == 3'd5 && i == m_q) n_isr[i] = 1'b0;
        end
        for (int i = 0; i < N; i++) begin
            if (m_edge[i]) n_pend[i] = (h1[i] && !h2[i]) || (m_pend[i] && !clrv[i]);
            else           n_pend[i] = h1[i];
        end
        if (m_rd) begin
            case (bus.addr)
                3'd0: n_rdata = 32'(m_pend);
                3'd1: n_rdata = 32'(m_mask);
                3'd2: n_rdata = 32'(m_edge);
                3'd3: n_rdata = m_win ? (32'h8000_0000 + 32'(m_p)) : 32'd0;
                3'd4: n_rdata = 32'(m_isr);
                default: n_rdata = 32'd0;
            endcase
        end
    end

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_pend <= '0; m_mask <= '0; m_edge <= '0; m_isr <= '0;
            h0 <= '0; h1 <= '0; h2 <= '0;
            m_rdata <= '0; m_ready <= 1'b0; m_int <= 1'b0; m_id <= 0;
        end else begin
            m_pend <= n_pend; m_mask <= n_mask; m_edge <= n_edge; m_isr <= n_isr;
            h0 <= irq; h1 <= h0; h2 <= h1;
            m_rdata <= n_rdata;
            m_ready <= bus.cs;
            m_int   <= m_win;
            m_id    <= m_win ? m_p : 0;
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (cmp_on) begin
            chk("cmp_int", 32'(int_o), 32'(m_int));
            chk("cmp_int_id", 32'(id_o), 32'(m_id));
            chk("cmp_ready", 32'(bus.ready), 32'(m_ready));
            chk("cmp_rdata", bus.rdata, m_rdata);
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
        bus.cs = 1'b1; bus.mem_w = 1'b1; bus.addr = a; bus.wdata = d;
        tick();
        bus.cs = 1'b0; bus.mem_w = 1'b0;
    endtask

    task automatic bus_read(input logic [2:0] a, output logic [31:0] d);
        bus.cs = 1'b1; bus.mem_w = 1'b0; bus.addr = a;
        tick();
        d = bus.rdata;
        bus.cs = 1'b0;
    endtask

    task automatic read_chk(input string nm, input logic [2:0] a, input logic [31:0] exp);
        logic [31:0] d;
        bus_read(a, d);
        chk(nm, d, exp);
    endtask

    initial begin
        logic [31:0] r;
        bus.cs = 1'b0; bus.mem_w = 1'b0; bus.addr = '0; bus.wdata = '0;
        #1 reset = 1'b0;
        cmp_on = 1'b1;
        repeat (3) @(posedge clk);
        #2 reset = 1'b1;
        tick();

        read_chk("rst_mask", 3'd1, 32'h0);
        read_chk("rst_edge", 3'd2, 32'h0);
        read_chk("rst_pend", 3'd0, 32'h0);
        read_chk("rst_isr", 3'd4, 32'h0);

        // Edge path: one-cycle pulse on source 3.
        bus_write(3'd2, 32'h08);
        bus_write(3'd1, 32'h08);
        irq = 8'h08;
        tick();
        irq = 8'h00;
        chk("edge_e0_int", 32'(int_o), 32'd0);
        tick();
        chk("edge_e1_int", 32'(int_o), 32'd0);
        tick();
        chk("edge_e2_int", 32'(int_o), 32'd0);
        tick();
        chk("edge_e3_int", 32'(int_o), 32'd1);
        chk("edge_e3_id", 32'(id_o), 32'd3);
        read_chk("edge_claim", 3'd3, 32'h8000_0003);
        tick();
        chk("edge_int_fall", 32'(int_o), 32'd0);
        read_chk("edge_isr", 3'd4, 32'h08);
        bus_write(3'd5, 32'h0);
        read_chk("edge_isr_eoi", 3'd4, 32'h0);

        // Priority and preemption.
        bus_write(3'd2, 32'hFF);
        bus_write(3'd1, 32'hFF);
        irq = 8'h10;
        ticks(5);
        read_chk("prio_claim4", 3'd3, 32'h8000_0004);
        irq = 8'h50;
        ticks(5);
        chk("prio_src6_blocked", 32'(int_o), 32'd0);
        irq = 8'h52;
        ticks(5);
        chk("prio_src1_int", 32'(int_o), 32'd1);
        chk("prio_src1_id", 32'(id_o), 32'd1);
        read_chk("prio_claim1", 3'd3, 32'h8000_0001);
        read_chk("prio_isr", 3'd4, 32'h12);
        bus_write(3'd5, 32'h0);
        read_chk("prio_isr_eoi1", 3'd4, 32'h10);
        bus_write(3'd5, 32'h0);
        ticks(2);
        read_chk("prio_claim6", 3'd3, 32'h8000_0006);
        bus_write(3'd5, 32'h0);
        irq = 8'h00;
        ticks(4);

        // Level source 0.
        bus_write(3'd2, 32'h00);
        bus_write(3'd1, 32'h01);
        irq = 8'h01;
        ticks(5);
        read_chk("lvl_pend", 3'd0, 32'h01);
        read_chk("lvl_claim", 3'd3, 32'h8000_0000);
        ticks(2);
        chk("lvl_int_in_service", 32'(int_o), 32'd0);
        bus_write(3'd5, 32'h0);
        tick();
        chk("lvl_int_reassert", 32'(int_o), 32'd1);
        irq = 8'h00;
        ticks(4);
        read_chk("lvl_pend_drop", 3'd0, 32'h00);

        // Set/clear collision on edge source 2.
        bus_write(3'd1, 32'h00);
        bus_write(3'd2, 32'h04);
        irq = 8'h04;
        ticks(2);
        bus_write(3'd0, 32'h04);
        read_chk("coll_pend_kept", 3'd0, 32'h04);
        bus_write(3'd0, 32'h04);
        read_chk("coll_pend_w1c", 3'd0, 32'h00);
        irq = 8'h00;

        // Empty claim and empty EOI.
        read_chk("empty_claim", 3'd3, 32'h0);
        chk("empty_claim_ready", 32'(bus.ready), 32'd1);
        bus_write(3'd5, 32'h0);
        read_chk("empty_eoi_isr", 3'd4, 32'h0);
        read_chk("empty_eoi_edge", 3'd2, 32'h04);
        read_chk("unused_reg6", 3'd6, 32'h0);

        // Randomized traffic, checked cycle by cycle against the model.
        bus_write(3'd2, $urandom);
        bus_write(3'd1, $urandom);
        for (int c = 0; c < 4000; c++) begin
            int k;
            logic [31:0] rb;
            rb  = $urandom & $urandom & $urandom;
            irq = irq ^ rb[N-1:0];
            k   = int'($urandom_range(0, 11));
            bus.cs = 1'b1;
            bus.wdata = $urandom;
            case (k)
                0, 1, 2, 3: bus.cs = 1'b0;
                4, 5:  begin bus.mem_w = 1'b0; bus.addr = 3'd3; end
                6:     begin bus.mem_w = 1'b0; bus.addr = 3'($urandom_range(0, 7)); end
                7, 8:  begin bus.mem_w = 1'b1; bus.addr = 3'd5; end
                9:     begin bus.mem_w = 1'b1; bus.addr = 3'd1; end
                10:    begin bus.mem_w = 1'b1; bus.addr = 3'd2; end
                default: begin bus.mem_w = 1'b1; bus.addr = 3'($urandom_range(0, 7)); end
            endcase
            tick();
        end
        bus.cs = 1'b0; bus.mem_w = 1'b0;

        // Reset in the middle of activity with PEND and ISR nonzero.
        irq = 8'h00;
        bus_write(3'd2, 32'hFF);
        bus_write(3'd1, 32'hFF);
        for (int i = 0; i < N; i++) bus_write(3'd5, 32'h0);
        ticks(4);
        bus_write(3'd0, 32'hFF);
        irq = 8'h21;
        ticks(5);
        read_chk("pre_rst_claim", 3'd3, 32'h8000_0000);
        read_chk("pre_rst_pend", 3'd0, 32'h20);
        reset = 1'b0;
        #1;
        chk("rst_async_int", 32'(int_o), 32'd0);
        chk("rst_async_id", 32'(id_o), 32'd0);
        chk("rst_async_ready", 32'(bus.ready), 32'd0);
        chk("rst_async_rdata", bus.rdata, 32'd0);
        irq = 8'h00;
        ticks(2);
        reset = 1'b1;
        ticks(3);
        read_chk("post_rst_mask", 3'd1, 32'h0);
        read_chk("post_rst_edge", 3'd2, 32'h0);
        read_chk("post_rst_pend", 3'd0, 32'h0);
        read_chk("post_rst_isr", 3'd4, 32'h0);
        ticks(2);

        cmp_on = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/int_ctrl.md
# int_ctrl

Memory-mapped, priority-vectored interrupt controller that drives the `INT` input of the pipelined `SCPU`. It synchronises `NSRC` external interrupt requests and latches them as pending, per source as edge or level. It masks them and resolves the highest-priority eligible source against an in-service stack. The CPU services it through word registers on the data bus (`Addr_out` / `Data_out` / `mem_w` decoded by the bus glue into `cs`) with a claim/EOI handshake.

## Interface
Parameters:
- `NSRC`, default 8: number of interrupt sources, 1..32; index 0 is highest priority.
- `IDW`, default 5: width of `int_id`; must satisfy `2**IDW >= NSRC`.

Ports:
- `clk`, input, 1: single clock, rising edge.
- `reset`, input, 1: asynchronous, active-low; clears all state.
- `irq_in`, input, `NSRC`: raw device requests, asynchronous to `clk`.
- `cs`, input, 1: bus select; one access per cycle while high.
- `mem_w`, input, 1: 1 = write, 0 = read (qualified by `cs`).
- `addr`, input, 3: word offset (byte address bits [4:2]).
- `wdata`, input, 32: write data.
- `rdata`, output, 32: read data, registered.
- `ready`, output, 1: one-cycle pulse, the cycle after any `cs` access.
- `INT`, output, 1: interrupt request to `SCPU`, registered.
- `int_id`, output, `IDW`: index of the current winning source, registered; 0 when `INT` = 0.

## Operation
Registers (bits at or above `NSRC` read 0 and ignore writes):
- 0 PEND (R/W1C): pending bits. W1C affects edge sources only.
- 1 MASK (RW): 1 = source enabled. Reset value 0.
- 2 EDGE (RW): 1 = edge-triggered, 0 = level. Reset value 0.
- 3 VEC (R, claim): {bit31 = valid, bits[IDW-1:0] = id}.
- 4 ISR (R): in-service bits.
- 5 EOI (W): any write clears the lowest-index set ISR bit.
- 6, 7: read 0; writes ignored.

Request path:
- Each `irq_in` bit passes through a 2-flop synchroniser (s1, s2), then a delay flop s3.
- Edge source: PEND bit is set when s2 & ~s3. It is cleared by W1C or by a claim. If a set and a clear occur in the same cycle, set wins.
- Level source: PEND bit is loaded with s2 every cycle. W1C and claim do not clear it; the device must drop its request.

Arbitration (combinational, registered into `INT` / `int_id`):
- elig = PEND & MASK.
- p = lowest index set in elig.
- q = lowest index set in ISR (q = NSRC if ISR = 0).
- The winner exists iff elig ≠ 0 and p < q. This gives strict preemption only by higher priority.

Claim (read of VEC while `cs` = 1 and `mem_w` = 0):
- If a winner exists: return {1, p}, set ISR[p], and clear PEND[p] if p is an edge source. All in that cycle's edge.
- If no winner exists: return 0; no state change.

EOI with ISR = 0: no effect.

## Timing
- Reset (async, while `reset` = 0): `rdata` = 0, `ready` = 0, `INT` = 0, `int_id` = 0. s1/s2/s3, PEND, MASK, EDGE and ISR are all 0. Asserting reset mid-claim discards the claim.
- Request latency, with edge E0 being the first edge to sample `irq_in` high: s1 at E0, s2 at E1, PEND at E2, `INT` at E3. The minimum request-to-INT latency is 3 cycles after E0.
- Register access: `cs` is sampled at edge E. `rdata` and `ready` are valid after E, and `ready` lasts one cycle. Register side effects (write, claim, EOI) take effect at E. Arbitration sees the new state at E+1, so `INT` reflects it after E+1.
- A MASK write that disables the only pending source: `INT` falls one cycle after the write edge.
- Back-to-back accesses, one per cycle, are legal. Each access produces its own `ready` pulse.
- `rdata` holds its last value when there is no access.

## Test plan
- Reset: drive `reset` = 0 mid-operation with PEND/ISR nonzero → all outputs are 0 immediately. After release, MASK/EDGE/PEND/ISR read back 0.
- Edge path: EDGE = 0x08, MASK = 0x08, pulse `irq_in[3]` for 1 cycle → `INT` = 1 and `int_id` = 3 three cycles after the sample. VEC read returns 0x80000003 → `INT` falls. ISR reads 0x08. EOI → ISR reads 0.
- Priority/preemption: claim source 4. Then raise source 6 → `INT` stays 0. Raise source 1 → `INT` = 1, `int_id` = 1. VEC read returns 0x80000001, and ISR then reads 0x12.
- Level source: EDGE = 0, MASK = 0x01, hold `irq_in[0]` = 1. Claim returns 0x80000000, then EOI → `INT` reasserts. Drop `irq_in[0]` → PEND bit 0 clears 3 cycles later.
- Set/clear collision: W1C PEND bit 2 in the same cycle that the bit 2 edge is detected → PEND[2] remains 1.
- Empty claim and empty EOI: VEC read with MASK = 0 → returns 0, with a `ready` pulse. EOI with ISR = 0 → no state change.
